// File: rtl/gol_nbr_window_gen.sv
// rtl/gol_nbr_window_gen.sv - Game of Life neighbour window generator
//
// Takes a raster stream of cells (row-major, x fastest, one cell per
// handshake) and produces, for every cell, its state plus its eight
// neighbours. Cells outside the field read as dead. There is no wrap-around.
//
// Ports:
//   i_clk, i_rst_n   clock (rising edge), asynchronous active-low reset
//   i_valid, i_cell  input cell stream; accepted when i_valid & o_ready
//   o_ready          input may be accepted this cycle
//   o_valid          output window valid; consumed when o_valid & i_out_ready
//   i_out_ready      downstream ready
//   o_cell_state     centre cell state
//   o_nbrs           [0]=NW [1]=N [2]=NE [3]=W [4]=E [5]=SW [6]=S [7]=SE
//   o_x, o_y         centre coordinates
//   o_frame_done     pulses as the window for (W-1,H-1) is consumed
module gol_nbr_window_gen #(
    parameter int FIELD_W = 64,
    parameter int FIELD_H = 48,
    localparam int XW = $clog2(FIELD_W),
    localparam int YW = $clog2(FIELD_H)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_valid,
    input  logic          i_cell,
    output logic          o_ready,
    output logic          o_valid,
    input  logic          i_out_ready,
    output logic          o_cell_state,
    output logic [7:0]    o_nbrs,
    output logic [XW-1:0] o_x,
    output logic [YW-1:0] o_y,
    output logic          o_frame_done
);

    // The window for cell j is complete once sample j+D has arrived (its SE
    // neighbour), so the pipeline runs D samples behind the input.
    localparam int D        = FIELD_W + 1;
    localparam int CELLS    = FIELD_W * FIELD_H;
    localparam int LAST_CNT = CELLS + D;
    localparam int CW       = $clog2(LAST_CNT + 1);
    localparam int SRW      = 2 * FIELD_W + 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t          state_q, state_d;
    // Only SRW-1 samples are stored; the incoming sample completes the window.
    logic [SRW-2:0]  sr_q;
    logic [SRW-1:0]  win;
    logic [CW-1:0]   cnt_q;
    logic [XW-1:0]   nx_q;
    logic [YW-1:0]   ny_q;

    logic            out_free;
    logic            accept;
    logic            adv;
    logic            sample;
    logic            win_ready;
    logic [7:0]      nbr_raw;
    logic [7:0]      nbr_mask;
    logic            at_l, at_r, at_t, at_b;

    assign out_free  = !o_valid || i_out_ready;
    // Gated by i_rst_n so the source sees no ready while reset is held.
    assign o_ready   = i_rst_n && (state_q != FLUSH) && out_free;
    assign accept    = i_valid && o_ready;
    assign adv       = accept || ((state_q == FLUSH) && out_free);
    assign sample    = (state_q == FLUSH) ? 1'b0 : i_cell;
    assign win       = {sr_q, sample};
    assign win_ready = (cnt_q >= CW'(D));

    assign o_frame_done = o_valid && i_out_ready &&
                          (o_x == XW'(FIELD_W - 1)) && (o_y == YW'(FIELD_H - 1));

    // win[0] is the newest sample (SE of the window being formed); older
    // samples sit one position further up per raster step.
    always_comb begin
        nbr_raw[0] = win[2*FIELD_W + 2];
        nbr_raw[1] = win[2*FIELD_W + 1];
        nbr_raw[2] = win[2*FIELD_W];
        nbr_raw[3] = win[FIELD_W + 2];
        nbr_raw[4] = win[FIELD_W];
        nbr_raw[5] = win[2];
        nbr_raw[6] = win[1];
        nbr_raw[7] = win[0];
    end

    assign at_l = (nx_q == '0);
    assign at_r = (nx_q == XW'(FIELD_W - 1));
    assign at_t = (ny_q == '0);
    assign at_b = (ny_q == YW'(FIELD_H - 1));

    // Edge neighbours would otherwise pick up cells from the adjacent row
    // or from stale shift-register contents.
    always_comb begin
        nbr_mask = 8'hFF;
        if (at_l) begin
            nbr_mask[0] = 1'b0;
            nbr_mask[3] = 1'b0;
            nbr_mask[5] = 1'b0;
        end
        if (at_r) begin
            nbr_mask[2] = 1'b0;
            nbr_mask[4] = 1'b0;
            nbr_mask[7] = 1'b0;
        end
        if (at_t) begin
            nbr_mask[0] = 1'b0;
            nbr_mask[1] = 1'b0;
            nbr_mask[2] = 1'b0;
        end
        if (at_b) begin
            nbr_mask[5] = 1'b0;
            nbr_mask[6] = 1'b0;
            nbr_mask[7] = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (accept && (cnt_q == CW'(CELLS - 1))) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                // The last flush step registers window (W-1,H-1); a new
                // frame may start as soon as that window is consumed.
                if (adv && (cnt_q == CW'(LAST_CNT - 1))) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= IDLE;
            sr_q         <= '0;
            cnt_q        <= '0;
            nx_q         <= '0;
            ny_q         <= '0;
            o_valid      <= 1'b0;
            o_cell_state <= 1'b0;
            o_nbrs       <= '0;
            o_x          <= '0;
            o_y          <= '0;
        end else begin
            state_q <= state_d;
            if (adv) begin
                sr_q  <= win[SRW-2:0];
                cnt_q <= (cnt_q == CW'(LAST_CNT - 1)) ? '0 : cnt_q + 1'b1;
                if (win_ready) begin
                    o_valid      <= 1'b1;
                    o_cell_state <= win[FIELD_W + 1];
                    o_nbrs       <= nbr_raw & nbr_mask;
                    o_x          <= nx_q;
                    o_y          <= ny_q;
                    if (at_r) begin
                        nx_q <= '0;
                        ny_q <= at_b ? '0 : ny_q + 1'b1;
                    end else begin
                        nx_q <= nx_q + 1'b1;
                    end
                end else begin
                    // adv implies the previous window was free to go.
                    o_valid <= 1'b0;
                end
            end else if (i_out_ready) begin
                o_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_gol_nbr_window_gen.sv
// tb/tb_gol_nbr_window_gen.sv - self-checking bench for gol_nbr_window_gen
module tb_gol_nbr_window_gen;

    localparam int W = 4;
    localparam int H = 3;
    localparam int N = W * H;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_valid = 1'b0;
    logic       i_cell = 1'b0;
    logic       o_ready;
    logic       o_valid;
    logic       i_out_ready = 1'b0;
    logic       o_cell_state;
    logic [7:0] o_nbrs;
    logic [1:0] o_x;
    logic [1:0] o_y;
    logic       o_frame_done;

    gol_nbr_window_gen #(.FIELD_W(W), .FIELD_H(H)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_valid      (i_valid),
        .i_cell       (i_cell),
        .o_ready      (o_ready),
        .o_valid      (o_valid),
        .i_out_ready  (i_out_ready),
        .o_cell_state (o_cell_state),
        .o_nbrs       (o_nbrs),
        .o_x          (o_x),
        .o_y          (o_y),
        .o_frame_done (o_frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0] win;
        int         j;
    } exp_t;

    exp_t       q[$];
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         out_stall = 0;
    int         frame_cells = 0;
    int         done_cnt = 0;
    bit         hold = 0;
    logic [12:0] hold_val;
    logic [8:0] got_win[N];
    int         seen_cyc[N];
    int         acc_cyc[N];

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        i_out_ready = ($urandom_range(99) >= out_stall);
    end

    task automatic chk(input string name, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Reference: neighbours straight from 2D geometry, dead outside the field.
    function automatic logic [8:0] model_win(input logic [N-1:0] f, input int j);
        int dx[8] = '{-1, 0, 1, -1, 1, -1, 0, 1};
        int dy[8] = '{-1, -1, -1, 0, 0, 1, 1, 1};
        int x = j % W;
        int y = j / W;
        logic [7:0] nb = '0;
        for (int k = 0; k < 8; k++) begin
            int cx = x + dx[k];
            int cy = y + dy[k];
            if (cx >= 0 && cx < W && cy >= 0 && cy < H) nb[k] = f[cy*W + cx];
        end
        return {f[j], nb};
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            frame_cells = 0;
            hold = 0;
        end else begin
            if (hold) begin
                chk("hold_valid", o_valid, 1);
                chk("hold_data", {o_cell_state, o_nbrs, o_x, o_y}, hold_val);
            end
            if (frame_cells == N && !(o_valid && o_x == 2'(W-1) && o_y == 2'(H-1)))
                chk("flush_ready", o_ready, 0);
            if (o_valid && i_out_ready) begin
                int j;
                j = int'(o_y) * W + int'(o_x);
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_window got=(%0d,%0d) exp=none", o_x, o_y);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("win_index", j, e.j);
                    chk("win_data", {o_cell_state, o_nbrs}, e.win);
                end
                chk("frame_done", o_frame_done, (j == N-1));
                if (j < N) begin
                    got_win[j] = {o_cell_state, o_nbrs};
                    seen_cyc[j] = cyc;
                end
                if (o_frame_done) done_cnt++;
                if (j == N-1) frame_cells = 0;
            end else begin
                chk("frame_done_idle", o_frame_done, 0);
            end
            if (i_valid && o_ready) frame_cells++;
            hold = o_valid && !i_out_ready;
            hold_val = {o_cell_state, o_nbrs, o_x, o_y};
        end
    end

    task automatic send_frame(input logic [N-1:0] f, input int ncells, input int in_stall);
        for (int j = 0; j < N; j++) begin
            exp_t e;
            e.win = model_win(f, j);
            e.j = j;
            q.push_back(e);
        end
        for (int k = 0; k < ncells; k++) begin
            bit acc;
            while ($urandom_range(99) < in_stall) begin
                i_valid = 0;
                @(posedge clk);
                #1;
            end
            i_valid = 1;
            i_cell = f[k];
            acc = 0;
            for (int t = 0; t < 200 && !acc; t++) begin
                @(negedge clk);
                acc = o_ready;
                if (acc) acc_cyc[k] = cyc + 1;
                @(posedge clk);
                #1;
            end
            if (!acc) begin
                total++;
                bad++;
                $display("FAIL accept_timeout got=cell%0d exp=accepted", k);
            end
        end
        i_valid = 0;
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 1000 && q.size() != 0; t++) begin
            @(posedge clk);
            #1;
        end
        chk("drain", q.size(), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] f;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", o_valid, 0);
        chk("rst_ready", o_ready, 0);
        chk("rst_done", o_frame_done, 0);
        chk("rst_nbrs", o_nbrs, 0);
        chk("rst_xy", {o_x, o_y}, 0);
        chk("rst_cell", o_cell_state, 0);
        rst_n = 1;
        @(posedge clk);
        #1;

        // All-ones field, no stalls: literals, latency, single frame_done.
        done_cnt = 0;
        send_frame('1, N, 0);
        wait_drain();
        chk("ones_00", got_win[0], 9'h1D0);
        chk("ones_10", got_win[1], 9'h1F8);
        chk("ones_11", got_win[5], 9'h1FF);
        chk("ones_32", got_win[11], 9'h10B);
        chk("ones_done_cnt", done_cnt, 1);
        chk("lat_first", seen_cyc[0], acc_cyc[5]);
        chk("lat_last", seen_cyc[N-1], acc_cyc[N-1] + 5);

        // Single live cell at (1,1).
        send_frame(N'(1) << 5, N, 0);
        wait_drain();
        chk("single_00", got_win[0], 9'h080);
        chk("single_22", got_win[10], 9'h001);
        chk("single_11", got_win[5], 9'h100);

        // Random fields under random input and output stalls.
        out_stall = 40;
        for (int r = 0; r < 6; r++) begin
            f = N'($urandom);
            send_frame(f, N, 30);
            wait_drain();
        end

        // Back-to-back frames, ones then zeros, then random pairs with stalls.
        out_stall = 0;
        send_frame('1, N, 0);
        send_frame('0, N, 0);
        wait_drain();
        out_stall = 30;
        for (int r = 0; r < 3; r++) begin
            send_frame(N'($urandom), N, 20);
            send_frame(N'($urandom), N, 20);
            wait_drain();
        end

        // Reset mid-frame after seven cells.
        out_stall = 0;
        @(posedge clk);
        #1;
        send_frame('1, 7, 0);
        chk("pre_reset_valid", o_valid, 1);
        #2;
        rst_n = 0;
        #1;
        chk("async_rst_valid", o_valid, 0);
        chk("async_rst_ready", o_ready, 0);
        q.delete();
        @(posedge clk);
        #1;
        rst_n = 1;
        f = N'($urandom);
        send_frame(f, N, 0);
        wait_drain();
        out_stall = 35;
        send_frame(N'($urandom), N, 25);
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gol_nbr_window_gen.md
Name: gol_nbr_window_gen

Overview:
- Producer side of the per-cell next-state interface.
- Accepts a Game of Life field as a raster stream, one cell per handshake, row-major, x fastest.
- Emits, for every cell, its current state plus an 8-bit neighbour vector, ready to drive the combinational next-state logic.
- Sits between field storage (frame readout) and the next-state/write-back path. Cells outside the field are dead; there is no wrap-around.

Parameters:
- FIELD_W, 64, field width in cells (>=2).
- FIELD_H, 48, field height in cells (>=2).

Ports:
- i_clk  input  1  single clock, rising edge.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_valid  input  1  input cell valid.
- i_cell  input  1  input cell state (1 = alive).
- o_ready  output  1  input cell accepted when i_valid & o_ready.
- o_valid  output  1  output window valid.
- i_out_ready  input  1  downstream accepts the window when o_valid & i_out_ready.
- o_cell_state  output  1  state of the centre cell.
- o_nbrs  output  8  neighbours: [0]=NW [1]=N [2]=NE [3]=W [4]=E [5]=SW [6]=S [7]=SE.
- o_x  output  $clog2(FIELD_W)  centre x.
- o_y  output  $clog2(FIELD_H)  centre y.
- o_frame_done  output  1  one-cycle pulse on the cycle the last window (W-1,H-1) is accepted.

Behaviour:
- Reset: all outputs 0 (o_ready 0 while i_rst_n low), shift register and counters cleared, state IDLE. Reset mid-frame discards the frame; the next accepted cell is (0,0).
- Storage: 2*FIELD_W+3-bit shift register. Sample count cnt in 0..W*H+D, where D = FIELD_W+1.
- States and transitions:
  - IDLE: o_ready=1; first accepted cell -> RUN.
  - RUN: accepts cells until cnt reaches W*H -> FLUSH.
  - FLUSH: o_ready=0; injects D zero samples internally -> IDLE.
- Advance condition: adv = (RUN/IDLE accept) | (FLUSH & (!o_valid | i_out_ready)).
- o_ready = state!=FLUSH & (!o_valid | i_out_ready). Full back-pressure; no input is lost.
- On each advance:
  - Shift in the sample; cnt++.
  - If cnt+1 > D, register the window for output index j = cnt+1-D-1 and set o_valid=1.
  - Otherwise, if the old output was consumed, set o_valid=0.
- Output registers hold while o_valid & !i_out_ready. No advance occurs while a window is pending unconsumed.
- Latency: the window for cell j is valid the cycle after sample j+D is accepted, or after the matching flush step.
- Masking by (o_x,o_y): x=0 clears NW,W,SW; x=W-1 clears NE,E,SE; y=0 clears NW,N,NE; y=H-1 clears SW,S,SE. Edge bits must be masked, not taken from the previous or next row.
- o_x/o_y wrap: x W-1 -> 0 with y++; after (W-1,H-1), coordinates return to (0,0).
- o_frame_done is asserted with the acceptance of window (W-1,H-1). The same cycle, the block enters IDLE with o_ready=1.
- Input presented during FLUSH is ignored (o_ready=0); the source must hold it.
- Throughput: 1 cell/cycle sustained with i_valid=i_out_ready=1. A frame takes W*H+D cycles plus stalls.

Test Plan:
- Test field is W=4, H=3 (D=5).
- All-ones field, no stalls -> 12 windows in raster order:
  - (0,0) nbrs=0xD0
  - (1,0) 0xF8
  - (1,1) 0xFF
  - (3,2) 0x0B
  - o_cell_state=1 throughout
  - o_frame_done exactly once, on (3,2).
- Single live cell at (1,1) -> (0,0) nbrs=0x80; (2,2) nbrs=0x01; (1,1) cell=1 nbrs=0x00; all other windows have at most one bit set, matching geometry.
- Latency: continuous input -> first o_valid in the cycle after the 6th accepted cell; last window 5 cycles after the 12th cell.
- Random i_out_ready/i_valid stalls on a random field -> window sequence identical to the no-stall run; o_nbrs/o_x/o_y stable while o_valid & !i_out_ready; o_ready=0 throughout FLUSH.
- Two back-to-back frames -> the second frame's (0,0) window contains no first-frame data; coordinates restart at (0,0).
- i_rst_n pulsed low mid-frame (after 7 cells) -> o_valid=0 immediately (asynchronous). A fresh frame then produces correct windows from (0,0).
